instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses program memory, and captures the returned word into the IR for decode.
// Latency: an instruction is valid one edge after it is addressed; a branch target is valid two edges after branch_en.
// Backpressure: ir_valid && !ir_ready freezes the PC and the IR; branch_en flushes the IR regardless of ir_ready.
module instruction_fetch #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] NULL_INSTR = {INSTR_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  input  logic [INSTR_WIDTH-1:0] pm_data,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0]  ir_pc,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   halted
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0]  ir_pc_q, ir_pc_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   halted_q, halted_d;
  logic                   load;

  // A new word is taken only when the IR slot is free or being drained this cycle.
  assign load = (state_q == FETCH) && (!ir_valid_q || ir_ready) && !branch_en;

  // Next-state logic: branch redirect outranks everything; HALT waits for a branch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;

    if (branch_en) begin
      pc_d       = branch_addr;
      ir_valid_d = 1'b0;
      state_d    = FETCH;
      halted_d   = 1'b0;
    end else if (state_q == HALT) begin
      ir_valid_d = 1'b0;
      halted_d   = 1'b1;
    end else if (load) begin
      if (pm_data == NULL_INSTR) begin
        // The null word is never handed to decode; the PC parks on it.
        ir_valid_d = 1'b0;
        state_d    = HALT;
        halted_d   = 1'b1;
      end else begin
        ir_d       = pm_data;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign pm_addr  = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural ROM stub plus an in-order scoreboard of accepted instructions.
// Latency: expected words are queued when stimulus is set up and retired on each valid/ready handshake.
// Backpressure: ir_ready is driven directly by the scenarios, including a random pattern.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pm_addr;
  logic [15:0] pm_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_addr = '0;
  logic        halted;

  typedef struct packed {
    logic [15:0] ir;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rom [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  instruction_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .NULL_INSTR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_data(pm_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_en(branch_en), .branch_addr(branch_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  // Combinational ROM stub.
  always_comb pm_data = rom[pm_addr];

  // Retire one expected word per handshake; branch cycles flush rather than hand off.
  always @(negedge clk) begin
    if (!rst && !branch_en && ir_valid && ir_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got ir=%h ir_pc=%0d, queue empty", ir, ir_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ir !== e.ir || ir_pc !== e.pc) begin
          n_fail++;
          $display("FAIL sb_order got ir=%h ir_pc=%0d exp ir=%h ir_pc=%0d", ir, ir_pc, e.ir, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (pm_addr !== 8'd0)   begin n_fail++; $display("FAIL rst_pm_addr got %0d exp 0", pm_addr); end
    n_checks++; if (ir !== 16'h0)       begin n_fail++; $display("FAIL rst_ir got %h exp 0000", ir); end
    n_checks++; if (ir_pc !== 8'd0)     begin n_fail++; $display("FAIL rst_ir_pc got %0d exp 0", ir_pc); end
    n_checks++; if (ir_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_ir_valid got %b exp 0", ir_valid); end
    n_checks++; if (halted !== 1'b0)    begin n_fail++; $display("FAIL rst_halted got %b exp 0", halted); end
  endtask

  // Expects rst high on entry; releases it and streams the first two words.
  task automatic test_stream();
    step();
    rst = 1'b0;
    ir_ready = 1'b1;
    sb.push_back('{ir: 16'hA203, pc: 8'd0});
    n_checks++; if (ir_valid !== 1'b0 || pm_addr !== 8'd0) begin
      n_fail++; $display("FAIL stream_idle got valid=%b pm_addr=%0d exp 0/0", ir_valid, pm_addr);
    end
    step();
    n_checks++; if (ir !== 16'hA203 || ir_pc !== 8'd0 || ir_valid !== 1'b1 || pm_addr !== 8'd1) begin
      n_fail++; $display("FAIL stream_edge1 got ir=%h pc=%0d v=%b pm=%0d exp A203/0/1/1", ir, ir_pc, ir_valid, pm_addr);
    end
    step();
    n_checks++; if (ir !== 16'hA305 || ir_pc !== 8'd1 || ir_valid !== 1'b1 || pm_addr !== 8'd2) begin
      n_fail++; $display("FAIL stream_edge2 got ir=%h pc=%0d v=%b pm=%0d exp A305/1/1/2", ir, ir_pc, ir_valid, pm_addr);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_stall();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    ir_ready = 1'b0;
    sb.push_back('{ir: 16'hA203, pc: 8'd0});
    step();
    n_checks++; if (ir !== 16'hA203 || ir_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_load got ir=%h v=%b exp A203/1", ir, ir_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ir !== 16'hA203 || ir_pc !== 8'd0 || ir_valid !== 1'b1 || pm_addr !== 8'd1) begin
        n_fail++; $display("FAIL stall_hold%0d got ir=%h pc=%0d v=%b pm=%0d exp A203/0/1/1", i, ir, ir_pc, ir_valid, pm_addr);
      end
    end
    ir_ready = 1'b1;
    step();
    n_checks++; if (ir !== 16'hA305 || ir_pc !== 8'd1 || pm_addr !== 8'd2) begin
      n_fail++; $display("FAIL stall_release got ir=%h pc=%0d pm=%0d exp A305/1/2", ir, ir_pc, pm_addr);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_branch_halt();
    branch_en = 1'b1;
    branch_addr = 8'd255;
    step();
    n_checks++; if (ir_valid !== 1'b0 || pm_addr !== 8'd255 || halted !== 1'b0) begin
      n_fail++; $display("FAIL br_flush got v=%b pm=%0d halted=%b exp 0/255/0", ir_valid, pm_addr, halted);
    end
    branch_en = 1'b0;
    ir_ready = 1'b1;
    step();
    n_checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || ir !== 16'hA305 || ir_pc !== 8'd1) begin
      n_fail++; $display("FAIL br_null got halted=%b v=%b ir=%h pc=%0d exp 1/0/A305/1", halted, ir_valid, ir, ir_pc);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (pm_addr !== 8'd255 || halted !== 1'b1 || ir_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold%0d got pm=%0d halted=%b v=%b exp 255/1/0", i, pm_addr, halted, ir_valid);
      end
    end
  endtask

  task automatic test_halt_exit();
    ir_ready = 1'b0;
    branch_en = 1'b1;
    branch_addr = 8'd0;
    step();
    n_checks++; if (halted !== 1'b0 || pm_addr !== 8'd0 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL exit_redirect got halted=%b pm=%0d v=%b exp 0/0/0", halted, pm_addr, ir_valid);
    end
    branch_en = 1'b0;
    step();
    n_checks++; if (ir !== 16'hA203 || ir_pc !== 8'd0 || ir_valid !== 1'b1 || pm_addr !== 8'd1) begin
      n_fail++; $display("FAIL exit_load got ir=%h pc=%0d v=%b pm=%0d exp A203/0/1/1", ir, ir_pc, ir_valid, pm_addr);
    end
  endtask

  task automatic test_wrap();
    int i;
    rom[255] = 16'h1234;
    branch_en = 1'b1;
    branch_addr = 8'd255;
    ir_ready = 1'b1;
    step();
    n_checks++; if (ir_valid !== 1'b0 || pm_addr !== 8'd255) begin
      n_fail++; $display("FAIL wrap_redirect got v=%b pm=%0d exp 0/255", ir_valid, pm_addr);
    end
    branch_en = 1'b0;
    sb.push_back('{ir: 16'h1234, pc: 8'd255});
    sb.push_back('{ir: 16'hA203, pc: 8'd0});
    step();
    n_checks++; if (ir !== 16'h1234 || ir_pc !== 8'd255 || ir_valid !== 1'b1 || pm_addr !== 8'd0) begin
      n_fail++; $display("FAIL wrap_top got ir=%h pc=%0d v=%b pm=%0d exp 1234/255/1/0", ir, ir_pc, ir_valid, pm_addr);
    end
    step();
    n_checks++; if (ir !== 16'hA203 || ir_pc !== 8'd0 || pm_addr !== 8'd1) begin
      n_fail++; $display("FAIL wrap_zero got ir=%h pc=%0d pm=%0d exp A203/0/1", ir, ir_pc, pm_addr);
    end
    i = 0;
    while (sb.size() != 0 && i < 10) begin
      step();
      i++;
    end
    ir_ready = 1'b0;
    n_checks++; if (sb.size() != 0) begin
      n_fail++; $display("FAIL wrap_drain got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    ir_ready = 1'b1;
    sb.push_back('{ir: rom[1], pc: 8'd1});
    sb.push_back('{ir: rom[2], pc: 8'd2});
    sb.push_back('{ir: rom[3], pc: 8'd3});
    step();
    step();
    step();
    ir_ready = 1'b0;
    n_checks++; if (ir_valid !== 1'b1 || pm_addr !== 8'd5 || ir !== rom[4] || ir_pc !== 8'd4) begin
      n_fail++; $display("FAIL arst_pre got v=%b pm=%0d ir=%h pc=%0d exp 1/5/%h/4", ir_valid, pm_addr, ir, ir_pc, rom[4]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ir_valid !== 1'b0 || ir !== 16'h0 || ir_pc !== 8'd0 || halted !== 1'b0 || pm_addr !== 8'd0) begin
      n_fail++; $display("FAIL arst_clear got v=%b ir=%h pc=%0d halted=%b pm=%0d exp all 0", ir_valid, ir, ir_pc, halted, pm_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prev_ir;
    logic        prev_v;
    logic        prev_rdy;
    int          i;
    for (int k = 1; k <= 60; k++) sb.push_back('{ir: rom[k], pc: 8'(k)});
    for (int c = 0; c < 40; c++) begin
      ir_ready = 1'($urandom_range(0, 1));
      prev_ir  = ir;
      prev_v   = ir_valid;
      prev_rdy = ir_ready;
      step();
      if (prev_v && !prev_rdy) begin
        n_checks++; if (ir !== prev_ir || ir_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_stable got ir=%h v=%b exp %h/1", ir, ir_valid, prev_ir);
        end
      end
    end
    ir_ready = 1'b1;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      step();
      i++;
    end
    ir_ready = 1'b0;
    n_checks++; if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain got %0d pending exp 0", sb.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 16'h1000 + 16'(k);
    rom[0]   = 16'hA203;
    rom[1]   = 16'hA305;
    rom[255] = 16'hFFFF;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_branch_halt();
    test_halt_exit();
    test_wrap();
    test_async_reset();
    test_stream();
    test_back_to_back();
    step();
    n_checks++; if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
